// File: rtl/w_grf_writeback_pkg.sv
// ---------------------------------------------------------------------------
// w_grf_writeback_pkg
// Shared pipeline definitions for the writeback stage: write-data select
// codes (RegWDsel) and load extraction codes (ldext). The controller and the
// M/W pipeline register drive the same encodings.
// ---------------------------------------------------------------------------
package w_grf_writeback_pkg;

    localparam int XLEN        = 32;
    localparam int NREG        = 32;
    localparam int LINK_OFFSET = 8;

    // Write-data select; codes 5..15 are unused and select zero.
    typedef enum logic [3:0] {
        WD_ALU  = 4'd0,
        WD_MEM  = 4'd1,
        WD_LINK = 4'd2,
        WD_HI   = 4'd3,
        WD_LO   = 4'd4
    } regwdsel_e;

    // Load extraction mode; codes 5..7 are unused and produce zero.
    typedef enum logic [2:0] {
        LD_W  = 3'd0,
        LD_B  = 3'd1,
        LD_BU = 3'd2,
        LD_H  = 3'd3,
        LD_HU = 3'd4
    } ldext_e;

endpackage

// File: rtl/w_grf_writeback_load_ext.sv
// ---------------------------------------------------------------------------
// w_grf_writeback_load_ext
// Pure combinational load extraction / extension of an aligned memory word.
//   memread_i [31:0]  raw aligned data-memory word (byte 0 = bits [7:0])
//   offset_i  [1:0]   byte offset of the access inside the word
//   ldext_i   [2:0]   extraction mode (LD_* codes)
//   data_o    [31:0]  extracted, extended load value
// ---------------------------------------------------------------------------
module w_grf_writeback_load_ext
    import w_grf_writeback_pkg::*;
(
    input  logic [XLEN-1:0] memread_i,
    input  logic [1:0]      offset_i,
    input  logic [2:0]      ldext_i,
    output logic [XLEN-1:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // NOTE: every signal assigned in always_comb gets a default first so
    // that no path leaves it unassigned and infers a latch.
    always_comb begin
        byte_sel = memread_i[7:0];
        case (offset_i)
            2'd1:    byte_sel = memread_i[15:8];
            2'd2:    byte_sel = memread_i[23:16];
            2'd3:    byte_sel = memread_i[31:24];
            default: byte_sel = memread_i[7:0];
        endcase
        // Offset bit 0 is ignored for halfwords; misalignment traps earlier.
        half_sel = offset_i[1] ? memread_i[31:16] : memread_i[15:0];
    end

    always_comb begin
        data_o = '0;
        case (ldext_i)
            LD_W:    data_o = memread_i;
            LD_B:    data_o = {{24{byte_sel[7]}}, byte_sel};
            LD_BU:   data_o = {24'd0, byte_sel};
            LD_H:    data_o = {{16{half_sel[15]}}, half_sel};
            LD_HU:   data_o = {16'd0, half_sel};
            default: data_o = '0;
        endcase
    end

endmodule

// File: rtl/w_grf_writeback.sv
// ---------------------------------------------------------------------------
// w_grf_writeback
// Writeback stage plus the 32x32 general register file.
//   clk, reset                      clock, async active-low reset
//   w_pc_i/memread/aluout/hi/lo     M/W register payload
//   w_regwrite_i, w_rega3_i         commit request and destination
//   w_regwdsel_i, w_ldext_i         write-data select, load extraction mode
//   d_a1_i/d_a2_i -> d_rd1_o/d_rd2_o  D-stage read ports with W->D bypass
//   trace_*_o                       per-cycle commit trace
//   commit_cnt_o                    commits since reset (wraps)
// ---------------------------------------------------------------------------
module w_grf_writeback
    import w_grf_writeback_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] w_pc_i,
    input  logic [XLEN-1:0] w_memread_i,
    input  logic [XLEN-1:0] w_aluout_i,
    input  logic [XLEN-1:0] w_hi_i,
    input  logic [XLEN-1:0] w_lo_i,
    input  logic            w_regwrite_i,
    input  logic [4:0]      w_rega3_i,
    input  logic [3:0]      w_regwdsel_i,
    input  logic [2:0]      w_ldext_i,
    input  logic [4:0]      d_a1_i,
    input  logic [4:0]      d_a2_i,
    output logic [XLEN-1:0] d_rd1_o,
    output logic [XLEN-1:0] d_rd2_o,
    output logic            trace_we_o,
    output logic [XLEN-1:0] trace_pc_o,
    output logic [XLEN-1:0] trace_wd_o,
    output logic [4:0]      trace_a3_o,
    output logic [XLEN-1:0] commit_cnt_o
);

    // $0 is hard-wired to zero, so only 1..31 are stored.
    logic [XLEN-1:0] regs_q [1:NREG-1];
    logic [XLEN-1:0] regs_d [1:NREG-1];
    logic [XLEN-1:0] commit_cnt_q, commit_cnt_d;
    logic [XLEN-1:0] load_data;
    logic [XLEN-1:0] wd;
    logic            we;

    w_grf_writeback_load_ext u_load_ext (
        .memread_i (w_memread_i),
        .offset_i  (w_aluout_i[1:0]),
        .ldext_i   (w_ldext_i),
        .data_o    (load_data)
    );

    always_comb begin
        wd = '0;
        case (w_regwdsel_i)
            WD_ALU:  wd = w_aluout_i;
            WD_MEM:  wd = load_data;
            WD_LINK: wd = w_pc_i + XLEN'(LINK_OFFSET);
            WD_HI:   wd = w_hi_i;
            WD_LO:   wd = w_lo_i;
            default: wd = '0;
        endcase
        we = w_regwrite_i && (w_rega3_i != 5'd0);
    end

    always_comb begin
        regs_d = regs_q;
        if (we) begin
            regs_d[w_rega3_i] = wd;
        end
        commit_cnt_d = commit_cnt_q + (we ? XLEN'(1) : XLEN'(0));
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its pre-edge value, independent of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: the register array is reset explicitly because software
            // relies on all GPRs reading zero after reset; this rules out
            // mapping it onto a RAM macro without reset.
            for (int i = 1; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
            commit_cnt_q <= '0;
        end else begin
            regs_q       <= regs_d;
            commit_cnt_q <= commit_cnt_d;
        end
    end

    // Read ports: $0 reads zero, a same-cycle commit to the address bypasses.
    always_comb begin
        d_rd1_o = '0;
        d_rd2_o = '0;
        if (d_a1_i != 5'd0) begin
            d_rd1_o = (we && (w_rega3_i == d_a1_i)) ? wd : regs_q[d_a1_i];
        end
        if (d_a2_i != 5'd0) begin
            d_rd2_o = (we && (w_rega3_i == d_a2_i)) ? wd : regs_q[d_a2_i];
        end
    end

    assign trace_we_o   = we;
    assign trace_pc_o   = w_pc_i;
    assign trace_wd_o   = wd;
    assign trace_a3_o   = w_rega3_i;
    assign commit_cnt_o = commit_cnt_q;

endmodule

// File: doc/w_grf_writeback.md
# w_grf_writeback

Writeback stage plus general register file of the five-stage MIPS pipeline. Consumes the outputs of the M/W pipeline register (PC, memory read word, ALU result, HI, LO, write-enable, destination, write-data select), performs load extraction/extension and the final write-data selection, and commits to 32×32 GPRs. Serves the D stage with two combinational read ports carrying W→D write-through bypass, and emits a per-commit trace plus a commit counter for the testbench.

## Interface
- No parameters; all widths fixed by the ISA.
- clk  in  1  pipeline clock
- reset  in  1  asynchronous, active-low
- w_pc_i  in  32  PC of the instruction in W
- w_memread_i  in  32  raw aligned data-memory word
- w_aluout_i  in  32  ALU result; [1:0] is the load byte offset
- w_hi_i, w_lo_i  in  32 each  HI/LO values
- w_regwrite_i  in  1  commit request
- w_rega3_i  in  5  destination register
- w_regwdsel_i  in  4  write-data select
- w_ldext_i  in  3  load extraction mode
- d_a1_i, d_a2_i  in  5 each  D-stage read addresses
- d_rd1_o, d_rd2_o  out  32 each  read data (bypassed)
- trace_we_o  out  1  commit occurs this cycle
- trace_pc_o, trace_wd_o  out  32 each  committing PC, write data
- trace_a3_o  out  5  committing register
- commit_cnt_o  out  32  number of commits since reset

## Operation
- Load extraction on w_memread_i by w_ldext_i: 0 word (pass); 1 lb: byte at offset [1:0], sign-extended; 2 lbu: same, zero-extended; 3 lh: halfword selected by offset bit 1, sign-extended; 4 lhu: zero-extended; 5–7 treated as 0. Offset bit 0 ignored for halfwords (alignment is an M-stage exception, not handled here). Byte 0 = bits [7:0] (little-endian lanes).
- Write-data wd by w_regwdsel_i: 0 aluout; 1 extracted load; 2 w_pc_i + 8 (link, modulo 2^32); 3 hi; 4 lo; 5–15 → 32'h0.
- Effective write we = w_regwrite_i && (w_rega3_i != 0). $0 never written, always reads 0.
- Read port n: if d_an == 0 → 0; else if we && w_rega3_i == d_an → wd (bypass); else stored register.
- Trace outputs combinational: trace_we_o = we; trace_pc_o/a3/wd mirror w_pc_i, w_rega3_i, wd every cycle regardless of we.
- commit_cnt_o increments by 1 on each clock edge where we is 1; wraps 32'hFFFF_FFFF → 0.

## Timing
- Register update on posedge clk when we; value visible from the stored array the cycle after, and via bypass in the same cycle.
- Reads are zero-latency combinational.
- Reset (reset == 0): immediately, independent of clk, all registers 1–31 and commit_cnt_o go to 0; writes suppressed while asserted. Deassertion mid-stream: first edge with reset == 1 commits normally.
- Both read ports addressing the same register as the writer: both bypass.
- w_regwrite_i with w_rega3_i == 0: no write, no count, trace_we_o = 0.

## Structure
- Shared package (pipeline defs): RegWDsel codes (WD_ALU, WD_MEM, WD_LINK, WD_HI, WD_LO) and ldext codes (LD_W, LD_B, LD_BU, LD_H, LD_HU); the same constants are used by the controller and the M/W register.
- One sub-module natural: load_ext (pure combinational extraction/extension); register array, wd mux, bypass and counter stay in the top.

## Test plan
- Reset low mid-run after writing $5=32'h1234 → d_rd1_o for a1=5 reads 0 immediately, commit_cnt_o = 0.
- regwrite, a3=0, wdsel=ALU, aluout=32'hDEAD_BEEF → d_rd1 for a1=0 stays 0, trace_we_o=0, count unchanged.
- memread=32'h80FF_7F01, aluout[1:0]=3, ldext=lb → wd=32'hFFFF_FF80; lbu → 32'h0000_0080; lh offset 2 → 32'hFFFF_80FF; lhu → 32'h0000_80FF.
- wdsel=LINK, pc=32'h0000_3004, a3=31 → $31 = 32'h0000_300C; pc=32'hFFFF_FFFC → 32'h0000_0004.
- Same-cycle write $8=32'hA5A5_A5A5 with a1=a2=8 → both read ports return 32'hA5A5_A5A5 before the edge; stored after.
- Preload commit_cnt to 32'hFFFF_FFFF via 2^32−1 forced commits (or force) → next commit reads 0; wdsel=HI/LO select w_hi_i/w_lo_i exactly.
